// File: rtl/hit_rate_monitor.sv
// hit_rate_monitor: multi-channel windowed hit counter with latched rate, saturation, alarm and partial flags
//  i_clk, i_rst      clock, synchronous active-high reset
//  i_en              1 counts and times windows, 0 freezes everything and marks the window partial
//  i_hit             per-channel single-cycle hit strobes
//  i_sec_pulse       window-end strobe (WIN_MODE=0 only)
//  i_thresh          alarm threshold, sampled at window end
//  o_live            running counts, channel k at [k*CNT_W +: CNT_W]
//  o_rate            counts latched at the last window end
//  o_rate_valid      one-cycle pulse when the latched bank updates
//  o_sat, o_alarm    per-channel saturation and threshold flags of the last window
//  o_partial         last window was not fully enabled
//  o_win_idx         completed-window counter
module hit_rate_monitor #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 14,
    parameter int WIN_MODE   = 0,
    parameter int WIN_CYCLES = 100000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [NUM_CH-1:0]       i_hit,
    input  logic                    i_sec_pulse,
    input  logic [CNT_W-1:0]        i_thresh,
    output logic [NUM_CH*CNT_W-1:0] o_live,
    output logic [NUM_CH*CNT_W-1:0] o_rate,
    output logic                    o_rate_valid,
    output logic [NUM_CH-1:0]       o_sat,
    output logic [NUM_CH-1:0]       o_alarm,
    output logic                    o_partial,
    output logic [15:0]             o_win_idx
);
    localparam int TW = WIN_CYCLES > 2 ? $clog2(WIN_CYCLES) : 1;
    logic [TW-1:0]                   timer;
    logic [NUM_CH-1:0][CNT_W-1:0]    live;
    logic [NUM_CH-1:0][CNT_W-1:0]    rate;
    logic [NUM_CH-1:0]               sat_acc;
    logic                            partial_flag;
    logic                            evt;
    assign evt    = i_en & (WIN_MODE != 0 ? timer == TW'(WIN_CYCLES - 1) : i_sec_pulse);
    assign o_live = live;
    assign o_rate = rate;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer        <= '0;
            live         <= '0;
            rate         <= '0;
            sat_acc      <= '0;
            partial_flag <= 1'b1;
            o_rate_valid <= 1'b0;
            o_sat        <= '0;
            o_alarm      <= '0;
            o_partial    <= 1'b0;
            o_win_idx    <= '0;
        end else begin
            o_rate_valid <= evt;
            if (!i_en) begin
                partial_flag <= 1'b1;
            end else if (evt) begin
                timer        <= '0;
                rate         <= live;
                o_sat        <= sat_acc;
                sat_acc      <= '0;
                o_partial    <= partial_flag;
                partial_flag <= 1'b0;
                o_win_idx    <= o_win_idx + 16'd1;
                // a hit coincident with the window end opens the next window
                for (int k = 0; k < NUM_CH; k++) begin
                    live[k]    <= CNT_W'(i_hit[k]);
                    o_alarm[k] <= live[k] >= i_thresh;
                end
            end else begin
                timer <= timer + TW'(1);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (i_hit[k]) begin
                        if (&live[k]) sat_acc[k] <= 1'b1;
                        else live[k] <= live[k] + CNT_W'(1);
                    end
                end
            end
        end
    end
endmodule
